mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter D_BURST_MAX, default 4, max consecutive data grants while an instruction request waits; legal range 1..15.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port i_req_i  input  1  instruction fetch request.
REQ-007 SHALL have port i_addr_i  input  ADDR_W  fetch address.
REQ-008 SHALL have port i_ready_o  output  1  fetch request accepted this cycle.
REQ-009 SHALL have port i_rvalid_o  output  1  fetch data valid.
REQ-010 SHALL have port i_rdata_o  output  DATA_W  fetch data.
REQ-011 SHALL have port d_req_i  input  1  data access request.
REQ-012 SHALL have port d_we_i  input  1  data access is a write.
REQ-013 SHALL have port d_addr_i  input  ADDR_W  data address.
REQ-014 SHALL have port d_wdata_i  input  DATA_W  write data.
REQ-015 SHALL have port d_ready_o  output  1  data request accepted this cycle.
REQ-016 SHALL have port d_rvalid_o  output  1  data response (read data or write ack) valid.
REQ-017 SHALL have port d_rdata_o  output  DATA_W  read data.
REQ-018 SHALL have ports mem_req_o (out 1), mem_we_o (out 1), mem_addr_o (out ADDR_W), mem_wdata_o (out DATA_W), mem_ready_i (in 1), mem_rvalid_i (in 1), mem_rdata_i (in DATA_W): shared single-port memory.

Function
REQ-019 SHALL implement FSM states IDLE, WAIT_I, WAIT_D; at most one memory transaction outstanding.
REQ-020 In IDLE, mem_req_o SHALL equal i_req_i|d_req_i combinationally; mem_addr_o/mem_we_o/mem_wdata_o SHALL come from the selected requester (mem_we_o=0, mem_wdata_o=0 for instruction).
REQ-021 Selection SHALL be data-first, except instruction is selected when i_req_i=1 and burst_cnt=D_BURST_MAX.
REQ-022 Handshake: transfer occurs when mem_req_o=1 and mem_ready_i=1 in IDLE; the selected requester's ready output SHALL be 1 that cycle only; the other ready SHALL be 0.
REQ-023 On data transfer, next state WAIT_D; on instruction transfer, next state WAIT_I; with no transfer, stay IDLE.
REQ-024 burst_cnt (4 bits): +1 on data transfer while i_req_i=1, saturating at D_BURST_MAX; cleared on instruction transfer or when i_req_i=0 in IDLE.
REQ-025 In WAIT_I/WAIT_D, mem_req_o, i_ready_o, d_ready_o SHALL be 0.
REQ-026 In WAIT_I with mem_rvalid_i=1: i_rvalid_o=1, i_rdata_o=mem_rdata_i same cycle (combinational); next state IDLE.
REQ-027 In WAIT_D with mem_rvalid_i=1: d_rvalid_o=1, d_rdata_o=mem_rdata_i (write: ack, data don't-care); next state IDLE.
REQ-028 A new request SHALL NOT issue in the response cycle; minimum 2 cycles between transfers.
REQ-029 mem_rvalid_i in IDLE SHALL be ignored (no rvalid output, no state change).
REQ-030 i_rdata_o/d_rdata_o SHALL be 0 whenever the corresponding rvalid is 0.
REQ-031 Requesters hold req/addr/data stable until ready; arbiter need not register request inputs.

Reset
REQ-032 reset=1 SHALL force state IDLE and burst_cnt 0 immediately, independent of clk.
REQ-033 During reset all outputs SHALL be 0.
REQ-034 Reset mid-transaction SHALL drop the outstanding response; a later mem_rvalid_i is ignored per REQ-029.

Verification
REQ-035 Idle: i_req_i=1, addr 0x100, mem_ready_i=1 -> i_ready_o=1 cycle 0, state WAIT_I; mem_rvalid_i=1 with 0xDEADBEEF 2 cycles later -> i_rvalid_o=1, i_rdata_o=0xDEADBEEF.
REQ-036 Simultaneous i_req_i and d_req_i (d_we_i=1, addr 0x200, wdata 0x55) -> data granted, mem_we_o=1, mem_addr_o=0x200; instruction granted after data ack.
REQ-037 Starvation: continuous d_req_i and i_req_i, D_BURST_MAX=4 -> exactly 4 data grants then 1 instruction grant, repeating.
REQ-038 mem_ready_i=0 for 3 cycles with d_req_i=1 -> mem_req_o held 1, d_ready_o=0, state IDLE; grant on cycle mem_ready_i rises.
REQ-039 Reset asserted in WAIT_D, mem_rvalid_i=1 after release -> no d_rvalid_o, state IDLE, all outputs 0 during reset.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master arbiter (instruction fetch / data access) in front of a single-port memory.
// Data-first priority with a bounded data burst so a waiting fetch cannot starve.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int D_BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              i_ready_o,
  output logic              i_rvalid_o,
  output logic [DATA_W-1:0] i_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_ready_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ready_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;

  localparam logic [3:0] BURST_LIM = 4'(D_BURST_MAX);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] burst_cnt;
  logic       any_req;
  logic       sel_i;
  logic       xfer;

  assign any_req = i_req_i | d_req_i;
  // Fetch wins only when data is absent or data has used up its burst allowance.
  assign sel_i   = i_req_i & (~d_req_i | (burst_cnt == BURST_LIM));
  assign xfer    = (state == IDLE) & any_req & mem_ready_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer) state_nxt = sel_i ? WAIT_I : WAIT_D;
      WAIT_I:  if (mem_rvalid_i) state_nxt = IDLE;
      WAIT_D:  if (mem_rvalid_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counts data grants taken while a fetch is pending; any fetch grant or idle fetch port resets it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      burst_cnt <= 4'd0;
    end else if (state == IDLE) begin
      if (!i_req_i || (xfer && sel_i))
        burst_cnt <= 4'd0;
      else if (xfer && (burst_cnt != BURST_LIM))
        burst_cnt <= burst_cnt + 4'd1;
    end
  end

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    i_ready_o   = 1'b0;
    d_ready_o   = 1'b0;
    i_rvalid_o  = 1'b0;
    i_rdata_o   = '0;
    d_rvalid_o  = 1'b0;
    d_rdata_o   = '0;
    if (!reset) begin
      case (state)
        IDLE: begin
          mem_req_o = any_req;
          if (any_req) begin
            mem_addr_o  = sel_i ? i_addr_i : d_addr_i;
            mem_we_o    = ~sel_i & d_we_i;
            mem_wdata_o = sel_i ? '0 : d_wdata_i;
          end
          i_ready_o = xfer & sel_i;
          d_ready_o = xfer & ~sel_i;
        end
        WAIT_I: begin
          if (mem_rvalid_i) begin
            i_rvalid_o = 1'b1;
            i_rdata_o  = mem_rdata_i;
          end
        end
        WAIT_D: begin
          if (mem_rvalid_i) begin
            d_rvalid_o = 1'b1;
            d_rdata_o  = mem_rdata_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected grant/response events,
// a negedge monitor pops and compares them whenever the arbiter presents one.
module tb_mem_arbiter;

  localparam int K_IG = 0, K_DG = 1, K_IR = 2, K_DR = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req_i, d_req_i, d_we_i;
  logic [31:0] i_addr_i, d_addr_i, d_wdata_i;
  logic        i_ready_o, i_rvalid_o, d_ready_o, d_rvalid_o;
  logic [31:0] i_rdata_o, d_rdata_o;
  logic        mem_req_o, mem_we_o, mem_ready_i, mem_rvalid_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
    bit          chk_data;
  } ev_t;

  ev_t exp_q[$];
  int  n_total = 0;
  int  n_pass  = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .D_BURST_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_ready_o(i_ready_o),
    .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_ready_o(d_ready_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push(input int kind, input logic [31:0] addr, input logic we,
                      input logic [31:0] data, input bit chk_data);
    ev_t e;
    e.kind = kind; e.addr = addr; e.we = we; e.data = data; e.chk_data = chk_data;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL unexpected_event: kind %0d presented, none expected (t=%0t)", kind, $time);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", 32'(kind), 32'(e.kind));
      if (kind == K_IG || kind == K_DG) begin
        chk("grant_addr", mem_addr_o, e.addr);
        chk("grant_we", {31'd0, mem_we_o}, {31'd0, e.we});
        chk("grant_wdata", mem_wdata_o, e.data);
      end else if (e.chk_data) begin
        chk("resp_rdata", (kind == K_IR) ? i_rdata_o : d_rdata_o, e.data);
      end
    end
  endtask

  // Monitor: every presented handshake/response must match the next expected event.
  always @(negedge clk) begin
    if (i_ready_o && d_ready_o) begin
      n_total++;
      $display("FAIL both_ready: i_ready_o and d_ready_o both 1 (t=%0t)", $time);
    end
    if (i_ready_o)  check_ev(K_IG);
    if (d_ready_o)  check_ev(K_DG);
    if (i_rvalid_o) check_ev(K_IR);
    if (d_rvalid_o) check_ev(K_DR);
    if (!i_rvalid_o) chk("i_rdata_zero", i_rdata_o, 32'd0);
    if (!d_rvalid_o) chk("d_rdata_zero", d_rdata_o, 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"}, {31'd0, mem_req_o}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, mem_we_o}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr_o, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata_o, 32'd0);
    chk({tag, "_readys"}, {30'd0, i_ready_o, d_ready_o}, 32'd0);
    chk({tag, "_rvalids"}, {30'd0, i_rvalid_o, d_rvalid_o}, 32'd0);
    chk({tag, "_rdatas"}, i_rdata_o | d_rdata_o, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    i_req_i = 0; i_addr_i = 0; d_req_i = 0; d_we_i = 0; d_addr_i = 0; d_wdata_i = 0;
    mem_ready_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
    tick(); tick();
    @(negedge clk);
    chk_all_zero("reset_init");
    tick();
    reset = 1'b0;
    tick();
    chk("idle_no_req", {31'd0, mem_req_o}, 32'd0);

    // Single fetch, response two cycles after the grant.
    i_req_i = 1; i_addr_i = 32'h100; mem_ready_i = 1;
    push(K_IG, 32'h100, 1'b0, 32'd0, 1'b0);
    tick();
    i_req_i = 0; mem_ready_i = 0;
    d_req_i = 1; d_addr_i = 32'h7F0;
    @(negedge clk);
    chk("wait_i_no_req", {31'd0, mem_req_o}, 32'd0);
    tick();
    d_req_i = 0;
    mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF;
    push(K_IR, 32'd0, 1'b0, 32'hDEADBEEF, 1'b1);
    tick();
    // Stray rvalid while idle must be ignored.
    mem_rdata_i = 32'h11112222;
    @(negedge clk);
    chk("idle_rvalid_ignored", {30'd0, i_rvalid_o, d_rvalid_o}, 32'd0);
    tick();
    mem_rvalid_i = 0;

    // Simultaneous requests: data write goes first, fetch after the ack.
    i_req_i = 1; i_addr_i = 32'h300;
    d_req_i = 1; d_we_i = 1; d_addr_i = 32'h200; d_wdata_i = 32'h55; mem_ready_i = 1;
    push(K_DG, 32'h200, 1'b1, 32'h55, 1'b0);
    tick();
    d_req_i = 0; d_we_i = 0; d_wdata_i = 0;
    @(negedge clk);
    chk("wait_d_no_req", {31'd0, mem_req_o}, 32'd0);
    tick();
    mem_rvalid_i = 1; mem_rdata_i = 32'hCAFE0000;
    push(K_DR, 32'd0, 1'b0, 32'd0, 1'b0);
    tick();
    mem_rvalid_i = 0;
    push(K_IG, 32'h300, 1'b0, 32'd0, 1'b0);
    tick();
    i_req_i = 0; mem_ready_i = 0;
    mem_rvalid_i = 1; mem_rdata_i = 32'h12345678;
    push(K_IR, 32'd0, 1'b0, 32'h12345678, 1'b1);
    tick();
    mem_rvalid_i = 0;

    // Memory not ready for three cycles: request held, no grant.
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h400;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_mem_req", {31'd0, mem_req_o}, 32'd1);
      chk("stall_addr", mem_addr_o, 32'h400);
      tick();
    end
    mem_ready_i = 1;
    push(K_DG, 32'h400, 1'b0, 32'd0, 1'b0);
    tick();
    d_req_i = 0;
    mem_rvalid_i = 1; mem_rdata_i = 32'hA5A5A5A5;
    push(K_DR, 32'd0, 1'b0, 32'hA5A5A5A5, 1'b1);
    tick();
    mem_rvalid_i = 0;
    tick();

    // Starvation bound: four data grants then one fetch grant, twice over.
    i_req_i = 1; i_addr_i = 32'h1000;
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h2000;
    for (int k = 0; k < 10; k++) begin
      if (k % 5 == 4) push(K_IG, 32'h1000, 1'b0, 32'd0, 1'b0);
      else            push(K_DG, 32'h2000, 1'b0, 32'd0, 1'b0);
      tick();
      mem_rvalid_i = 1; mem_rdata_i = 32'hB000 + 32'(k);
      push((k % 5 == 4) ? K_IR : K_DR, 32'd0, 1'b0, 32'hB000 + 32'(k), 1'b1);
      tick();
      mem_rvalid_i = 0;
    end
    i_req_i = 0; d_req_i = 0; mem_ready_i = 0;
    tick();

    // Reset while a data write is outstanding drops its response.
    d_req_i = 1; d_we_i = 1; d_addr_i = 32'h500; d_wdata_i = 32'h77; mem_ready_i = 1;
    push(K_DG, 32'h500, 1'b1, 32'h77, 1'b0);
    tick();
    i_req_i = 1; i_addr_i = 32'h600; mem_rvalid_i = 1; mem_rdata_i = 32'h9999;
    #2 reset = 1'b1;
    @(negedge clk);
    chk_all_zero("reset_mid");
    tick();
    reset = 1'b0;
    i_req_i = 0; d_req_i = 0; d_we_i = 0; d_wdata_i = 0; mem_ready_i = 0;
    @(negedge clk);
    chk("post_reset_no_drvalid", {31'd0, d_rvalid_o}, 32'd0);
    tick();
    mem_rvalid_i = 0;
    // An immediate grant shows the arbiter came back in IDLE.
    i_req_i = 1; i_addr_i = 32'h700; mem_ready_i = 1;
    push(K_IG, 32'h700, 1'b0, 32'd0, 1'b0);
    tick();
    i_req_i = 0; mem_ready_i = 0;
    mem_rvalid_i = 1; mem_rdata_i = 32'h0BADF00D;
    push(K_IR, 32'd0, 1'b0, 32'h0BADF00D, 1'b1);
    tick();
    mem_rvalid_i = 0;
    tick(); tick();

    chk("pending_events", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
